// File: rtl/forward_propper_if.sv
`default_nettype none
// ============================================================================
//  Module      : forward_propper_if
//  Description : Operand/result bundle for the forward_propper neuron
//                evaluator. The master drives the operands and accepts the
//                result; the slave (the evaluator) does the reverse.
//  Revision    : 1.0  initial release
// ============================================================================
interface forward_propper_if;
  logic [31:0][31:0] fp_x;
  logic [32:0][31:0] fp_w;
  logic              fp_in_valid;
  logic              fp_in_ready;
  logic [31:0]       fp_net;
  logic [31:0]       fp_y;
  logic              fp_out_valid;
  logic              fp_out_ready;

  modport master (
    output fp_x, fp_w, fp_in_valid, fp_out_ready,
    input  fp_in_ready, fp_net, fp_y, fp_out_valid
  );

  modport slave (
    input  fp_x, fp_w, fp_in_valid, fp_out_ready,
    output fp_in_ready, fp_net, fp_y, fp_out_valid
  );
endinterface
`default_nettype wire

// File: rtl/forward_propper.sv
`default_nettype none
// ============================================================================
//  Module      : forward_propper
//  Description : Forward pass of one 32-input neuron plus threshold weight.
//                Operands are captured on acceptance, 33 Q16.16 products are
//                accumulated serially on one multiplier into a 56-bit sum,
//                then the sum is narrowed to 32 bits and passed through a
//                hard sigmoid. Both the sum and the activation are returned.
//                Optional macro FWD_SAT_EN: saturate (instead of wrap) the
//                accumulator when narrowing to 32 bits.
//  Revision    : 1.0  initial release
// ============================================================================
module forward_propper (
  input  wire logic         clk,
  input  wire logic         rst,
  forward_propper_if.slave  fp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_ACT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0]         c_LAST_IDX = 6'd32;
  localparam logic signed [31:0] c_ONE      = 32'sh0001_0000;
  localparam logic signed [31:0] c_HALF     = 32'sh0000_8000;

  state_t            state_q, state_d;
  logic [31:0][31:0] x_q, x_d;
  logic [32:0][31:0] w_q, w_d;
  logic signed [55:0] acc_q, acc_d;
  logic [5:0]        idx_q, idx_d;
  logic [31:0]       net_q, net_d;
  logic [31:0]       y_q, y_d;

  logic signed [31:0] mul_x;
  logic signed [63:0] prod;
  logic signed [47:0] term;
  logic [31:0]        net_n;
  logic signed [31:0] hs_t;
  logic [31:0]        y_n;
  logic               dropped_bits_unused;

  // Current MAC term: x[i]*w[i] arithmetically shifted down; slot 32 uses 1.0
  always_comb begin
    mul_x = (idx_q == c_LAST_IDX) ? c_ONE : $signed(x_q[idx_q[4:0]]);
    prod  = mul_x * $signed(w_q[idx_q]);
    term  = prod[63:16];
  end

  // Narrow the accumulator to 32 bits and apply the hard sigmoid
  always_comb begin
`ifdef FWD_SAT_EN
    if ((&acc_q[55:31]) || !(|acc_q[55:31])) begin
      net_n = acc_q[31:0];
    end else if (acc_q[55]) begin
      net_n = 32'h8000_0000;
    end else begin
      net_n = 32'h7FFF_FFFF;
    end
`else
    net_n = acc_q[31:0];
`endif
    hs_t = ($signed(net_n) >>> 2) + c_HALF;
    if (hs_t < 32'sd0) begin
      y_n = 32'h0000_0000;
    end else if (hs_t > c_ONE) begin
      y_n = 32'h0001_0000;
    end else begin
      y_n = hs_t;
    end
  end

  // Bits that are intentionally discarded by truncation/wrap
  assign dropped_bits_unused = ^{prod[15:0], acc_q[55:32]};

  // Next-state, operand capture and accumulation
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    w_d     = w_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    net_d   = net_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (fp.fp_in_valid) begin
          x_d     = fp.fp_x;
          w_d     = fp.fp_w;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{8{term[47]}}, term};
        idx_d = idx_q + 6'd1;
        if (idx_q == c_LAST_IDX) begin
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        net_d   = net_n;
        y_d     = y_n;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (fp.fp_out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, accumulator and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      net_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      net_q   <= net_d;
      y_q     <= y_d;
    end
  end

  // Operand holding registers; contents only matter after a capture
  always_ff @(posedge clk) begin
    x_q <= x_d;
    w_q <= w_d;
  end

  assign fp.fp_in_ready  = (state_q == S_IDLE);
  assign fp.fp_out_valid = (state_q == S_DONE);
  assign fp.fp_net       = net_q;
  assign fp.fp_y         = y_q;

endmodule
`default_nettype wire
